// File: rtl/async_fifo_rd_fwft_pkg.sv
// Shared helpers for the async FIFO read-domain output stage.
package async_fifo_rd_fwft_pkg;

  // Width of the output-buffer word count (holds 0..2).
  localparam int COUNT_W = 2;

  // Occupancy seen by the issue logic: buffered words plus the in-flight
  // read, minus the word leaving this cycle. Computed in 3 bits so the sum
  // cannot wrap. A pop implies count >= 1, so the subtraction never underflows.
  function automatic logic [2:0] fwft_occupancy(
    input logic [COUNT_W-1:0] count,
    input logic               inflight,
    input logic               pop
  );
    return {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/async_fifo_rd_fwft_chk.sv
// Checker for the read-domain output stage: the buffer never overflows.
module async_fifo_rd_fwft_chk (
  input logic       clk_i,
  input logic       rst_n_i,
  input logic       cap_i,
  input logic       pop_i,
  input logic [1:0] count_i
);

  // A capture into a full buffer without a simultaneous pop would drop data.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(cap_i && (count_i == 2'd2) && !pop_i));

  // Buffered words plus the in-flight read never exceed the buffer depth.
  a_occupancy: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (({1'b0, count_i} + {2'b00, cap_i}) <= 3'd2));

endmodule

// File: rtl/async_fifo_rd_fwft.sv
// Read-domain output stage of the async FIFO: turns the rd_en/rempty
// interface with one-cycle RAM read latency into a first-word-fall-through
// valid/ready stream using a 2-entry (head + skid) buffer.
module async_fifo_rd_fwft
  import async_fifo_rd_fwft_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  rclk_i,
  input  logic                  rresetn_i,
  input  logic                  rempty_i,
  output logic                  rd_en_o,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic [1:0]            m_count_o
);

  localparam logic [2:0] BUF_DEPTH = 3'd2;

  logic [COUNT_W-1:0]    r_count;
  logic                  r_inflight;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_skid;

  logic                  w_pop;
  logic                  w_issue;
  logic [2:0]            w_occ;
  logic [COUNT_W-1:0]    w_count_nxt;
  logic [DATA_WIDTH-1:0] w_head_nxt;
  logic [DATA_WIDTH-1:0] w_skid_nxt;

  assign w_pop = r_valid & m_ready_i;
  assign w_occ = fwft_occupancy(r_count, r_inflight, w_pop);
  // Held low during reset so the pointer controller never advances while
  // the output stage is being cleared.
  assign w_issue = rresetn_i & ~rempty_i & (w_occ < BUF_DEPTH);

  // Buffer next-state: capture the in-flight RAM word and/or retire the head.
  always_comb begin
    w_count_nxt = r_count;
    w_head_nxt  = r_head;
    w_skid_nxt  = r_skid;
    case ({r_inflight, w_pop})
      2'b10: begin
        case (r_count)
          2'd0: begin
            w_head_nxt  = rdata_i;
            w_count_nxt = 2'd1;
          end
          2'd1: begin
            w_skid_nxt  = rdata_i;
            w_count_nxt = 2'd2;
          end
          default: begin
          end
        endcase
      end
      2'b01: begin
        case (r_count)
          2'd2: begin
            w_head_nxt  = r_skid;
            w_count_nxt = 2'd1;
          end
          2'd1: begin
            w_count_nxt = 2'd0;
          end
          default: begin
          end
        endcase
      end
      2'b11: begin
        case (r_count)
          2'd1: begin
            w_head_nxt = rdata_i;
          end
          2'd2: begin
            w_head_nxt = r_skid;
            w_skid_nxt = rdata_i;
          end
          default: begin
          end
        endcase
      end
      default: begin
      end
    endcase
  end

  // Register stage: buffer, count, registered valid and in-flight flag.
  always_ff @(posedge rclk_i or negedge rresetn_i) begin
    if (!rresetn_i) begin
      r_count    <= 2'd0;
      r_inflight <= 1'b0;
      r_valid    <= 1'b0;
      r_head     <= {DATA_WIDTH{1'b0}};
      r_skid     <= {DATA_WIDTH{1'b0}};
    end else begin
      r_count    <= w_count_nxt;
      r_inflight <= w_issue;
      r_valid    <= (w_count_nxt != 2'd0);
      r_head     <= w_head_nxt;
      r_skid     <= w_skid_nxt;
    end
  end

  assign rd_en_o   = w_issue;
  assign m_valid_o = r_valid;
  assign m_data_o  = r_head;
  assign m_count_o = r_count;

endmodule
